// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: turns debounced button edges into FIFO write strobes.
// A single request writes the switch value once; a burst request writes the
// sequence 1..N, one entry per TICK_CYCLES interval. Requests or burst steps
// that meet a full FIFO are dropped and reported on overflow.
//
// Strobe interface: wr_en is a one-cycle write strobe and wr_data is valid in
// the same cycle. There is no back-pressure handshake; fifo_full is the only
// flow control and is checked in the cycle the write decision is made.
module fifo_write_ctrl #(
    parameter int WIDTH       = 4,
    parameter int TICK_CYCLES = 100000000,
    parameter int TIMER_W     = 27
) (
    input  logic             clk,
    input  logic             rst_edge,
    input  logic             wr_edge,
    input  logic             write_more_edge,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fifo_full,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [TIMER_W-1:0] TICK_LAST = TIMER_W'(TICK_CYCLES - 1);

    state_t             state, state_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [WIDTH-1:0]   count, count_n;
    logic [WIDTH-1:0]   iter, iter_n;
    logic [WIDTH-1:0]   iter_inc;
    logic               wr_en_n, done_n, overflow_n, busy_n;
    logic [WIDTH-1:0]   wr_data_n;

    assign iter_inc = iter + WIDTH'(1);

    // Register state, counters and every output; reset returns to an idle, quiet block.
    always_ff @(posedge clk or posedge rst_edge) begin
        if (rst_edge) begin
            state    <= IDLE;
            timer    <= '0;
            count    <= '0;
            iter     <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            count    <= count_n;
            iter     <= iter_n;
            wr_en    <= wr_en_n;
            wr_data  <= wr_data_n;
            busy     <= busy_n;
            done     <= done_n;
            overflow <= overflow_n;
        end
    end

    // Next-state and next-output decisions; pulses default low, wr_data holds.
    always_comb begin
        state_n    = state;
        timer_n    = timer;
        count_n    = count;
        iter_n     = iter;
        wr_en_n    = 1'b0;
        wr_data_n  = wr_data;
        done_n     = 1'b0;
        overflow_n = 1'b0;
        // busy trails the state by one cycle, so it rises the cycle after entry
        busy_n     = (state == BURST);

        case (state)
            IDLE: begin
                if (write_more_edge) begin
                    // a burst request swallows a simultaneous single request
                    if (fifo_full) begin
                        overflow_n = 1'b1;
                    end else if (data_in != '0) begin
                        count_n = data_in;
                        iter_n  = '0;
                        timer_n = '0;
                        state_n = BURST;
                    end
                end else if (wr_edge) begin
                    if (fifo_full) begin
                        overflow_n = 1'b1;
                    end else begin
                        wr_en_n   = 1'b1;
                        wr_data_n = data_in;
                    end
                end
            end

            BURST: begin
                // wr_edge is deliberately ignored while a burst runs
                if (write_more_edge) begin
                    // restart outranks a tick landing in the same cycle
                    if (fifo_full) begin
                        overflow_n = 1'b1;
                        state_n    = IDLE;
                    end else if (data_in == '0) begin
                        state_n = IDLE;
                    end else begin
                        count_n = data_in;
                        iter_n  = '0;
                        timer_n = '0;
                    end
                end else if (timer == TICK_LAST) begin
                    timer_n = '0;
                    if (fifo_full) begin
                        overflow_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        wr_en_n   = 1'b1;
                        wr_data_n = iter_inc;
                        iter_n    = iter_inc;
                        if (iter_inc == count) begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end else begin
                    timer_n = timer + TIMER_W'(1);
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Testbench for fifo_write_ctrl with a short tick interval (4 cycles).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A monitor pops the expected-data queue on every wr_en strobe.
module tb_fifo_write_ctrl;

    localparam int W    = 4;
    localparam int TICK = 4;

    logic         clk;
    logic         rst_edge;
    logic         wr_edge;
    logic         write_more_edge;
    logic [W-1:0] data_in;
    logic         fifo_full;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         busy;
    logic         done;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    fifo_write_ctrl #(
        .WIDTH      (W),
        .TICK_CYCLES(TICK),
        .TIMER_W    (4)
    ) dut (
        .clk            (clk),
        .rst_edge       (rst_edge),
        .wr_edge        (wr_edge),
        .write_more_edge(write_more_edge),
        .data_in        (data_in),
        .fifo_full      (fifo_full),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard monitor: every strobe must match the oldest expected value
    always @(negedge clk) begin
        logic [W-1:0] exp_d;
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: wr_en=1 wr_data=%0d, required no strobe", wr_data);
            end else begin
                exp_d = exp_q.pop_front();
                if (wr_data !== exp_d) begin
                    errors++;
                    $display("FAIL strobe_data: wr_data=%0d, required %0d", wr_data, exp_d);
                end
            end
        end
    end

    task automatic test_reset();
        logic [3:0] flags;
        rst_edge        = 1'b1;
        wr_edge         = 1'b0;
        write_more_edge = 1'b0;
        data_in         = '0;
        fifo_full       = 1'b0;
        repeat (3) @(negedge clk);
        flags = {wr_en, done, busy, overflow};
        checks++;
        if (flags !== 4'b0000 || wr_data !== '0) begin
            errors++;
            $display("FAIL reset_held: flags=%b wr_data=%0d, required 0000 and 0", flags, wr_data);
        end
        rst_edge = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            flags = {wr_en, done, busy, overflow};
            checks++;
            if (flags !== 4'b0000 || wr_data !== '0) begin
                errors++;
                $display("FAIL reset_idle c%0d: flags=%b wr_data=%0d, required 0000 and 0", k, flags, wr_data);
            end
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        data_in = 4'd9;
        wr_edge = 1'b1;
        exp_q.push_back(4'd9);
        @(negedge clk);
        wr_edge = 1'b0;
        data_in = 4'd2;
        checks++;
        if ({wr_en, busy, overflow} !== 3'b100) begin
            errors++;
            $display("FAIL single_strobe: wr_en/busy/overflow=%b, required 100", {wr_en, busy, overflow});
        end
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || wr_data !== 4'd9 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after: wr_en=%b wr_data=%0d busy=%b, required 0 9 0", wr_en, wr_data, busy);
        end
    endtask

    task automatic test_burst();
        logic [3:0] flags, exp;
        @(negedge clk);
        data_in         = 4'd3;
        write_more_edge = 1'b1;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            if (k == 0) begin
                write_more_edge = 1'b0;
                data_in         = 4'd0;
            end
            exp   = {(k == 4 || k == 8 || k == 12), (k == 12), (k >= 1 && k <= 12), 1'b0};
            flags = {wr_en, done, busy, overflow};
            checks++;
            if (flags !== exp) begin
                errors++;
                $display("FAIL burst3 T+%0d: en/done/busy/ovf=%b, required %b", k, flags, exp);
            end
        end
    endtask

    task automatic test_burst_full();
        logic [3:0] flags, exp;
        @(negedge clk);
        data_in         = 4'd5;
        write_more_edge = 1'b1;
        exp_q.push_back(4'd1);
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            if (k == 0) write_more_edge = 1'b0;
            if (k == 5) fifo_full = 1'b1;
            if (k == 9) fifo_full = 1'b0;
            exp   = {(k == 4), 1'b0, (k >= 1 && k <= 8), (k == 8)};
            flags = {wr_en, done, busy, overflow};
            checks++;
            if (flags !== exp) begin
                errors++;
                $display("FAIL burst_full T+%0d: en/done/busy/ovf=%b, required %b", k, flags, exp);
            end
        end
    endtask

    task automatic test_burst_restart();
        logic [3:0] flags, exp;
        @(negedge clk);
        data_in         = 4'd3;
        write_more_edge = 1'b1;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            exp   = {(k == 4 || k == 10 || k == 14), (k == 14), (k >= 1 && k <= 14), 1'b0};
            flags = {wr_en, done, busy, overflow};
            checks++;
            if (flags !== exp) begin
                errors++;
                $display("FAIL burst_restart T+%0d: en/done/busy/ovf=%b, required %b", k, flags, exp);
            end
            case (k)
                0: write_more_edge = 1'b0;
                2: begin wr_edge = 1'b1; data_in = 4'd7; end
                3: wr_edge = 1'b0;
                5: begin write_more_edge = 1'b1; data_in = 4'd2; end
                6: write_more_edge = 1'b0;
                default: ;
            endcase
        end
        checks++;
        if (wr_data !== 4'd2) begin
            errors++;
            $display("FAIL burst_restart_hold: wr_data=%0d, required 2", wr_data);
        end
    endtask

    task automatic test_corners();
        logic [3:0] flags;
        // both requests with a zero length: nothing happens
        @(negedge clk);
        data_in         = 4'd0;
        wr_edge         = 1'b1;
        write_more_edge = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wr_edge         = 1'b0;
            write_more_edge = 1'b0;
            flags = {wr_en, done, busy, overflow};
            checks++;
            if (flags !== 4'b0000) begin
                errors++;
                $display("FAIL both_zero c%0d: en/done/busy/ovf=%b, required 0000", k, flags);
            end
        end
        // single request against a full FIFO
        data_in   = 4'd6;
        wr_edge   = 1'b1;
        fifo_full = 1'b1;
        @(negedge clk);
        wr_edge = 1'b0;
        flags = {wr_en, done, busy, overflow};
        checks++;
        if (flags !== 4'b0001) begin
            errors++;
            $display("FAIL single_full: en/done/busy/ovf=%b, required 0001", flags);
        end
        // burst request against a full FIFO
        write_more_edge = 1'b1;
        @(negedge clk);
        write_more_edge = 1'b0;
        flags = {wr_en, done, busy, overflow};
        checks++;
        if (flags !== 4'b0001) begin
            errors++;
            $display("FAIL burst_req_full: en/done/busy/ovf=%b, required 0001", flags);
        end
        @(negedge clk);
        fifo_full = 1'b0;
        flags = {wr_en, done, busy, overflow};
        checks++;
        if (flags !== 4'b0000) begin
            errors++;
            $display("FAIL full_after: en/done/busy/ovf=%b, required 0000", flags);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] flags;
        @(negedge clk);
        data_in         = 4'd5;
        write_more_edge = 1'b1;
        exp_q.push_back(4'd1);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) write_more_edge = 1'b0;
            checks++;
            if (wr_en !== (k == 4)) begin
                errors++;
                $display("FAIL rst_burst_pre T+%0d: wr_en=%b, required %b", k, wr_en, (k == 4));
            end
        end
        rst_edge = 1'b1;
        #1;
        flags = {wr_en, done, busy, overflow};
        checks++;
        if (flags !== 4'b0000 || wr_data !== '0) begin
            errors++;
            $display("FAIL rst_async: flags=%b wr_data=%0d, required 0000 and 0", flags, wr_data);
        end
        repeat (2) @(negedge clk);
        rst_edge = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            flags = {wr_en, done, busy, overflow};
            checks++;
            if (flags !== 4'b0000) begin
                errors++;
                $display("FAIL rst_release c%0d: flags=%b, required 0000", k, flags);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_burst_full();
        test_burst_restart();
        test_corners();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL strobes_missing: %0d expected strobes never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
